// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Byte-producer request bundle shared by NUM_REQ requesters
//               and the UART transmit arbiter.
//               req_valid : per-requester byte valid (producer -> arbiter)
//               req_data  : per-requester byte, requester i in
//                           [i*DATA_BITS +: DATA_BITS] (producer -> arbiter)
//               req_ready : one-hot single-cycle accept pulse (arbiter -> producer)
//               master modport = producer side, slave modport = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter that shares one UART transmit line among
//               NUM_REQ byte producers and serializes the granted byte as an
//               8N1 frame, one oversample step per baud tick.
//               clock    : system clock
//               reset_n  : asynchronous active-low reset
//               tick     : oversample tick from the baud generator
//               req_if   : request bundle (valid/data in, ready out)
//               start_tx : single-cycle pulse to realign the baud generator
//               tx       : registered serial line, idle high
//               busy     : high from grant until the stop bit completes
//               grant_id : index of the current or last granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_BITS   = 8,
  parameter int SAMPLE_RATE = 16
) (
  input  wire logic                       clock,
  input  wire logic                       reset_n,
  input  wire logic                       tick,
  uart_tx_arbiter_if.slave                req_if,
  output logic                            start_tx,
  output logic                            tx,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(SAMPLE_RATE + 1);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_RATE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t                 state_q,     state_d;
  logic [CW-1:0]          tick_cnt_q,  tick_cnt_d;
  logic [BW-1:0]          bit_idx_q,   bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q,     shift_d;
  logic [GW-1:0]          last_q,      last_d;
  logic [GW-1:0]          grant_id_q,  grant_id_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
  logic                   start_tx_q,  start_tx_d;
  logic                   busy_q,      busy_d;
  logic                   tx_q,        tx_d;

  // Round-robin search: first valid requester at or after last+1, wrapping.
  logic                   win_found;
  logic [GW-1:0]          win_idx;
  logic [DATA_BITS-1:0]   win_data;
  int                     cand;
  logic [GW-1:0]          cand_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand     = (int'(last_q) + 1 + k) % NUM_REQ;
      cand_idx = cand[GW-1:0];
      if (!win_found && req_if.req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == GW'(i)) begin
        win_data = req_if.req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // A bit period closes on the tick that would bring the count to SAMPLE_RATE.
  logic period_end;
  assign period_end = tick && (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    last_d      = last_q;
    grant_id_d  = grant_id_q;
    busy_d      = busy_q;
    req_ready_d = '0;
    start_tx_d  = 1'b0;
    tx_d        = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        tick_cnt_d = '0;
        bit_idx_d  = '0;
        if (win_found) begin
          shift_d     = win_data;
          grant_id_d  = win_idx;
          last_d      = win_idx;
          req_ready_d = NUM_REQ'(1) << win_idx;
          start_tx_d  = 1'b1;
          busy_d      = 1'b1;
          state_d     = S_START;
        end
      end

      S_START: begin
        if (tick) begin
          if (period_end) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (period_end) begin
            tick_cnt_d = '0;
            shift_d    = shift_q >> 1;
            if (bit_idx_q == BIT_LAST) begin
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + BW'(1);
            end
          end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          if (period_end) begin
            tick_cnt_d = '0;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + CW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The line level is derived from the next state so that tx itself can be
    // a flop and still change on the same edge as the state register.
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      last_q      <= LAST_INIT;
      grant_id_q  <= '0;
      req_ready_q <= '0;
      start_tx_q  <= 1'b0;
      busy_q      <= 1'b0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      last_q      <= last_d;
      grant_id_q  <= grant_id_d;
      req_ready_q <= req_ready_d;
      start_tx_q  <= start_tx_d;
      busy_q      <= busy_d;
      tx_q        <= tx_d;
    end
  end

  assign req_if.req_ready = req_ready_q;
  assign start_tx         = start_tx_q;
  assign tx               = tx_q;
  assign busy             = busy_q;
  assign grant_id         = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter: reset and
//               idle behaviour, single frame, round-robin order, skip/wrap,
//               tick pacing through a baud generator model, reset mid-frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_BITS   = 8;
  localparam int SAMPLE_RATE = 16;

  logic       clock     = 1'b0;
  logic       reset_n   = 1'b0;
  logic       tick_drv  = 1'b0;
  logic       pace_mode = 1'b0;
  logic       tick;
  logic       start_tx;
  logic       tx;
  logic       busy;
  logic [1:0] grant_id;
  logic [1:0] div_q     = 2'd0;

  int n_assert = 0;
  int n_fail   = 0;
  int bad      = 0;

  logic [7:0] rr_byte  [4] = '{8'h00, 8'h11, 8'h22, 8'h33};
  int         rr_order [5] = '{0, 1, 2, 3, 0};

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_BITS(DATA_BITS)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .DATA_BITS   (DATA_BITS),
    .SAMPLE_RATE (SAMPLE_RATE)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .tick     (tick),
    .req_if   (bus),
    .start_tx (start_tx),
    .tx       (tx),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clock = ~clock;

  // Baud generator model, divide-by-4. The start_tx cycle is phase 0 of the
  // new bit, so the first tick lands 3 cycles after it and every 4 after.
  always @(posedge clock) begin
    if (start_tx) div_q <= 2'd1;
    else          div_q <= div_q + 2'd1;
  end
  assign tick = pace_mode ? ((div_q == 2'd3) && !start_tx) : tick_drv;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (bus.req_ready === 4'b0000 && n < 50) begin
      step();
      n++;
    end
    check({tag, "_grant_seen"}, 32'(bus.req_ready !== 4'b0000), 1);
  endtask

  // Called on the cycle req_ready is high; walks the whole frame.
  task automatic run_frame(input string tag, input int bitlen, input logic [7:0] b);
    int   bad_tx, extra, busy_low, drift;
    logic prev_tx, prev_tick, e_bit;
    bad_tx = 0; extra = 0; busy_low = 0; drift = 0;
    check({tag, "_start_pulse"}, start_tx, 1);
    prev_tx   = tx;
    prev_tick = tick;
    for (int j = 0; j < 10*bitlen; j++) begin
      if (j < bitlen)        e_bit = 1'b0;
      else if (j < 9*bitlen) e_bit = b[3'((j - bitlen) / bitlen)];
      else                   e_bit = 1'b1;
      if (tx !== e_bit) bad_tx++;
      if (j > 0 && (bus.req_ready !== 4'b0000 || start_tx !== 1'b0)) extra++;
      if (busy !== 1'b1) busy_low++;
      if (j > 0 && tx !== prev_tx && !prev_tick) drift++;
      prev_tx   = tx;
      prev_tick = tick;
      step();
    end
    check({tag, "_tx_cycles_wrong"}, bad_tx, 0);
    check({tag, "_extra_pulses"}, extra, 0);
    check({tag, "_busy_dropped"}, busy_low, 0);
    check({tag, "_tx_moved_without_tick"}, drift, 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_tx_end"}, tx, 1);
  endtask

  initial begin
    bus.req_valid = 4'b0000;
    bus.req_data  = '0;

    // Reset values
    repeat (3) step();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_start", start_tx, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_ready", bus.req_ready, 0);
    reset_n = 1'b1;

    // Idle with tick toggling and no requests
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick_drv = ~tick_drv;
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || start_tx !== 1'b0 ||
          grant_id !== 2'd0 || bus.req_ready !== 4'b0000) bad++;
    end
    check("idle_quiet", bad, 0);

    // Single request, tick every cycle, one-cycle grant latency
    tick_drv = 1'b1;
    bus.req_data[23:16] = 8'hA5;
    bus.req_valid = 4'b0100;
    check("single_pre_ready", bus.req_ready, 0);
    step();
    check("single_ready", bus.req_ready, 4'b0100);
    check("single_grant_id", grant_id, 2);
    check("single_busy", busy, 1);
    bus.req_valid = 4'b0000;
    run_frame("single", SAMPLE_RATE, 8'hA5);
    check("single_grant_id_hold", grant_id, 2);

    // Round robin from a fresh reset, all requesters always valid
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    bus.req_data  = 32'h3322_1100;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("rr");
      check("rr_ready", bus.req_ready, 32'(1) << rr_order[k]);
      check("rr_grant_id", grant_id, rr_order[k]);
      run_frame("rr", SAMPLE_RATE, rr_byte[rr_order[k]]);
    end

    // Skip and wrap
    bus.req_valid = 4'b1000;
    wait_grant("skip3");
    check("skip3_grant_id", grant_id, 3);
    bus.req_valid = 4'b0010;
    run_frame("skip3", SAMPLE_RATE, 8'h33);
    wait_grant("skip1");
    check("skip1_ready", bus.req_ready, 4'b0010);
    check("skip1_grant_id", grant_id, 1);
    bus.req_valid = 4'b0011;
    run_frame("skip1", SAMPLE_RATE, 8'h11);
    wait_grant("wrap0");
    check("wrap0_ready", bus.req_ready, 4'b0001);
    check("wrap0_grant_id", grant_id, 0);
    bus.req_valid = 4'b0000;
    run_frame("wrap0", SAMPLE_RATE, 8'h00);

    // Tick pacing: one tick per 4 cycles -> 64 cycles per bit
    pace_mode = 1'b1;
    bus.req_data[15:8] = 8'h96;
    bus.req_valid = 4'b0010;
    wait_grant("pace");
    check("pace_grant_id", grant_id, 1);
    bus.req_valid = 4'b0000;
    run_frame("pace", 4*SAMPLE_RATE, 8'h96);

    // Reset during DATA bit 3
    pace_mode = 1'b0;
    tick_drv  = 1'b1;
    bus.req_data  = {8'h00, 8'hA5, 8'h11, 8'h42};
    bus.req_valid = 4'b1000;
    wait_grant("mid");
    check("mid_grant_id", grant_id, 3);
    bus.req_valid = 4'b0101;
    repeat (70) step();
    check("mid_tx_low_bit3", tx, 0);
    check("mid_busy", busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx_async", tx, 1);
    check("mid_rst_busy_async", busy, 0);
    check("mid_rst_grant_id", grant_id, 0);
    step();
    step();
    check("mid_rst_no_ready", bus.req_ready, 0);
    reset_n = 1'b1;
    wait_grant("after_rst");
    check("after_rst_ready", bus.req_ready, 4'b0001);
    check("after_rst_grant_id", grant_id, 0);
    bus.req_valid = 4'b0100;
    run_frame("after_rst", SAMPLE_RATE, 8'h42);
    bus.req_valid = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
